// File: rtl/cmos_capture_data.sv
// ---------------------------------------------------------------------------
// cmos_capture_data
//
// Capture front end sitting between a raw 8-bit DVP camera bus and the
// ping-pong frame-RAM controller. The camera inputs are registered, the first
// WAIT_FRAMES frames after reset are discarded while the sensor settles, byte
// pairs are packed into 16-bit RGB565 pixels, and every output trails the
// matching camera input by exactly three cam_pclk cycles. Frames are counted
// and each frame's geometry is checked against H_PIXELS x V_LINES.
//
// Ports:
//   cam_pclk          in   1   pixel clock, the only clock
//   rst_n             in   1   asynchronous active-low reset
//   cam_vsync         in   1   camera frame sync, high pulse between frames
//   cam_href          in   1   camera line valid
//   cam_data          in   8   camera byte, high byte first
//   cmos_frame_vsync  out  1   gated vsync, 3 cycles behind cam_vsync
//   cmos_frame_href   out  1   gated href, 3 cycles behind cam_href
//   cmos_frame_clken  out  1   one-cycle pixel-valid strobe
//   cmos_frame_data   out  16  RGB565 pixel, valid while clken is high
//   frame_cnt         out  8   output frames started, wraps 255 -> 0
//   frame_err         out  1   geometry error of the previous frame
// ---------------------------------------------------------------------------
module cmos_capture_data #(
   parameter int unsigned WAIT_FRAMES = 10,
   parameter int unsigned H_PIXELS    = 320,
   parameter int unsigned V_LINES     = 240
) (
   input  logic        cam_pclk,
   input  logic        rst_n,
   input  logic        cam_vsync,
   input  logic        cam_href,
   input  logic [7:0]  cam_data,
   output logic        cmos_frame_vsync,
   output logic        cmos_frame_href,
   output logic        cmos_frame_clken,
   output logic [15:0] cmos_frame_data,
   output logic [7:0]  frame_cnt,
   output logic        frame_err
);

   // The counters are one value wider than needed so that the saturated
   // all-ones value can never equal the expected geometry; an overflowing
   // line or frame therefore still reports a mismatch.
   localparam int unsigned PIX_W  = $clog2(H_PIXELS + 2);
   localparam int unsigned LINE_W = $clog2(V_LINES + 2);

   localparam logic [PIX_W-1:0]  PIX_MAX     = '1;
   localparam logic [LINE_W-1:0] LINE_MAX    = '1;
   localparam logic [PIX_W-1:0]  PIX_TARGET  = PIX_W'(H_PIXELS);
   localparam logic [LINE_W-1:0] LINE_TARGET = LINE_W'(V_LINES);
   localparam logic [7:0]        WAIT_LAST   = 8'(WAIT_FRAMES - 1);

   // Input stage: d0 captures the pins, d1 gives the edge detectors their
   // previous value and feeds the delayed vsync/href outputs.
   logic        vsyncD0_q, vsyncD0_d;
   logic        vsyncD1_q, vsyncD1_d;
   logic        hrefD0_q,  hrefD0_d;
   logic        hrefD1_q,  hrefD1_d;
   logic [7:0]  dataD0_q,  dataD0_d;

   // Start-up qualification.
   logic [7:0]  waitCnt_q,    waitCnt_d;
   logic        frameValid_q, frameValid_d;

   // Byte pairing.
   logic        byteFlag_q, byteFlag_d;
   logic [7:0]  hiByte_q,   hiByte_d;

   // Output registers.
   logic        outVsync_q, outVsync_d;
   logic        outHref_q,  outHref_d;
   logic        outClken_q, outClken_d;
   logic [15:0] outData_q,  outData_d;

   // Geometry check.
   logic [PIX_W-1:0]  pixCnt_q,  pixCnt_d;
   logic [LINE_W-1:0] lineCnt_q, lineCnt_d;
   logic              lineBad_q, lineBad_d;
   logic [7:0]        frameCnt_q, frameCnt_d;
   logic              frameErr_q, frameErr_d;

   // Decoded events and the end-of-line view used by the frame check.
   logic              vsRise;
   logic              hrefFall;
   logic              pairEmit;
   logic              enableNow;
   logic              lineEndBad;
   logic [LINE_W-1:0] lineCntNext;
   logic              lineBadNext;

   // Event decode. A pair completes when the second byte of a pair sits in
   // d0. The enabling edge is the WAIT_FRAMES-th vsync rise after reset;
   // frameValid_q becomes set on the clock that registers that rise, one
   // cycle before the delayed vsync reaches the output register, so the
   // first output vsync pulse comes out whole.
   always_comb begin
      vsRise    = vsyncD0_q & ~vsyncD1_q;
      hrefFall  = ~hrefD0_q & hrefD1_q;
      pairEmit  = hrefD0_q & byteFlag_q;
      enableNow = vsRise & ~frameValid_q & (waitCnt_q == WAIT_LAST);
   end

   // Line/frame bookkeeping seen as if the current cycle's href fall had
   // already been applied. A line that ends on the same cycle as a vsync
   // rise therefore still belongs to the frame being closed. A byte flag
   // still set at the fall means a dangling high byte (odd byte count).
   always_comb begin
      lineEndBad  = 1'b0;
      lineCntNext = lineCnt_q;
      lineBadNext = lineBad_q;
      if (frameValid_q && hrefFall) begin
         lineEndBad  = (pixCnt_q != PIX_TARGET) | byteFlag_q;
         lineBadNext = lineBad_q | lineEndBad;
         if (lineCnt_q != LINE_MAX) begin
            lineCntNext = lineCnt_q + 1'b1;
         end
      end
   end

   // Next-state logic for every register. Defaults hold the current value;
   // the input stage simply follows the pins.
   always_comb begin
      vsyncD0_d    = cam_vsync;
      vsyncD1_d    = vsyncD0_q;
      hrefD0_d     = cam_href;
      hrefD1_d     = hrefD0_q;
      dataD0_d     = cam_data;

      waitCnt_d    = waitCnt_q;
      frameValid_d = frameValid_q;
      byteFlag_d   = 1'b0;
      hiByte_d     = hiByte_q;
      outVsync_d   = 1'b0;
      outHref_d    = 1'b0;
      outClken_d   = 1'b0;
      outData_d    = outData_q;
      pixCnt_d     = pixCnt_q;
      lineCnt_d    = lineCntNext;
      lineBad_d    = lineBadNext;
      frameCnt_d   = frameCnt_q;
      frameErr_d   = frameErr_q;

      // The wait counter freezes once output is enabled, so frameValid_q is
      // sticky until the next reset.
      if (vsRise && !frameValid_q) begin
         waitCnt_d = waitCnt_q + 8'd1;
      end
      if (enableNow) begin
         frameValid_d = 1'b1;
      end

      // Byte pairing: the flag restarts at every line so each line begins
      // with a high byte.
      if (hrefD0_q) begin
         byteFlag_d = ~byteFlag_q;
         if (!byteFlag_q) begin
            hiByte_d = dataD0_q;
         end
      end

      // Output stage, gated by the start-up qualification.
      if (frameValid_q) begin
         outVsync_d = vsyncD1_q;
         outHref_d  = hrefD1_q;
         outClken_d = pairEmit;
         if (pairEmit) begin
            outData_d = {hiByte_q, dataD0_q};
         end
      end

      // Pixels per line, saturating.
      if (frameValid_q) begin
         if (hrefFall) begin
            pixCnt_d = '0;
         end else if (pairEmit && (pixCnt_q != PIX_MAX)) begin
            pixCnt_d = pixCnt_q + 1'b1;
         end
      end

      // Frame boundary: judge the frame that just ended, then start a new
      // one. The enabling edge only opens the first frame and counts it.
      if (vsRise && (frameValid_q || enableNow)) begin
         frameCnt_d = frameCnt_q + 8'd1;
         lineCnt_d  = '0;
         lineBad_d  = 1'b0;
         if (frameValid_q) begin
            frameErr_d = (lineCntNext != LINE_TARGET) | lineBadNext;
         end
      end
   end

   // State register. Reset drops everything, including the wait count, so
   // a reset in the middle of a frame restarts sensor qualification.
   always_ff @(posedge cam_pclk or negedge rst_n) begin
      if (!rst_n) begin
         vsyncD0_q    <= 1'b0;
         vsyncD1_q    <= 1'b0;
         hrefD0_q     <= 1'b0;
         hrefD1_q     <= 1'b0;
         dataD0_q     <= 8'd0;
         waitCnt_q    <= 8'd0;
         frameValid_q <= 1'b0;
         byteFlag_q   <= 1'b0;
         hiByte_q     <= 8'd0;
         outVsync_q   <= 1'b0;
         outHref_q    <= 1'b0;
         outClken_q   <= 1'b0;
         outData_q    <= 16'd0;
         pixCnt_q     <= '0;
         lineCnt_q    <= '0;
         lineBad_q    <= 1'b0;
         frameCnt_q   <= 8'd0;
         frameErr_q   <= 1'b0;
      end else begin
         vsyncD0_q    <= vsyncD0_d;
         vsyncD1_q    <= vsyncD1_d;
         hrefD0_q     <= hrefD0_d;
         hrefD1_q     <= hrefD1_d;
         dataD0_q     <= dataD0_d;
         waitCnt_q    <= waitCnt_d;
         frameValid_q <= frameValid_d;
         byteFlag_q   <= byteFlag_d;
         hiByte_q     <= hiByte_d;
         outVsync_q   <= outVsync_d;
         outHref_q    <= outHref_d;
         outClken_q   <= outClken_d;
         outData_q    <= outData_d;
         pixCnt_q     <= pixCnt_d;
         lineCnt_q    <= lineCnt_d;
         lineBad_q    <= lineBad_d;
         frameCnt_q   <= frameCnt_d;
         frameErr_q   <= frameErr_d;
      end
   end

   assign cmos_frame_vsync = outVsync_q;
   assign cmos_frame_href  = outHref_q;
   assign cmos_frame_clken = outClken_q;
   assign cmos_frame_data  = outData_q;
   assign frame_cnt        = frameCnt_q;
   assign frame_err        = frameErr_q;

endmodule

// File: tb/tb_cmos_capture_data.sv
// ---------------------------------------------------------------------------
// tb_cmos_capture_data
//
// Directed bench for cmos_capture_data configured with WAIT_FRAMES=2,
// H_PIXELS=4, V_LINES=3. Inputs change 1 ns after each rising edge and
// outputs are sampled at the same point, so an input driven in cycle k is
// seen on the outputs in cycle k+3.
// ---------------------------------------------------------------------------
module tb_cmos_capture_data;

   logic        cam_pclk  = 1'b0;
   logic        rst_n     = 1'b0;
   logic        cam_vsync = 1'b0;
   logic        cam_href  = 1'b0;
   logic [7:0]  cam_data  = 8'd0;
   logic        cmos_frame_vsync;
   logic        cmos_frame_href;
   logic        cmos_frame_clken;
   logic [15:0] cmos_frame_data;
   logic [7:0]  frame_cnt;
   logic        frame_err;

   int checks      = 0;
   int failures    = 0;
   int activeCount = 0;
   int clkenCount  = 0;
   int activeBase;
   int clkenBase;
   logic [7:0] expCnt;

   // Hand-built expectations for the first enabled line F8 1F 07 E0 12 34 56 78,
   // indexed by cycle relative to the first byte.
   logic [11:0] expHrefTbl  = 12'b0111_1111_1000;
   logic [11:0] expClkenTbl = 12'b0010_1010_1000;
   logic [15:0] expDataTbl [12] = '{16'h0000, 16'h0000, 16'h0000, 16'hF81F,
                                    16'hF81F, 16'h07E0, 16'h07E0, 16'h1234,
                                    16'h1234, 16'h5678, 16'h5678, 16'h5678};
   logic [7:0]  lineBytes [8] = '{8'hF8, 8'h1F, 8'h07, 8'hE0,
                                  8'h12, 8'h34, 8'h56, 8'h78};

   cmos_capture_data #(
      .WAIT_FRAMES (2),
      .H_PIXELS    (4),
      .V_LINES     (3)
   ) dut (
      .cam_pclk         (cam_pclk),
      .rst_n            (rst_n),
      .cam_vsync        (cam_vsync),
      .cam_href         (cam_href),
      .cam_data         (cam_data),
      .cmos_frame_vsync (cmos_frame_vsync),
      .cmos_frame_href  (cmos_frame_href),
      .cmos_frame_clken (cmos_frame_clken),
      .cmos_frame_data  (cmos_frame_data),
      .frame_cnt        (frame_cnt),
      .frame_err        (frame_err)
   );

   // 100 MHz pixel clock.
   always #5 cam_pclk = ~cam_pclk;

   // Activity monitor on the falling edge: counts cycles with any visible
   // output and counts pixel strobes, for the quiet-period and strobe checks.
   always @(negedge cam_pclk) begin
      if (rst_n && (cmos_frame_vsync || cmos_frame_href || cmos_frame_clken ||
                    (cmos_frame_data != 16'd0))) begin
         activeCount = activeCount + 1;
      end
      if (cmos_frame_clken) begin
         clkenCount = clkenCount + 1;
      end
   end

   // Drives one cycle of camera inputs and advances to the next cycle.
   task automatic applyStimulus(input logic v, input logic h, input logic [7:0] d);
      cam_vsync = v;
      cam_href  = h;
      cam_data  = d;
      @(posedge cam_pclk);
      #1;
   endtask

   // One comparison: counts it, and counts and reports it on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks = checks + 1;
      assert (observed === expected) else begin
         failures = failures + 1;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_vsync"}, 32'(cmos_frame_vsync), 32'd0);
      checkOutput({tag, "_href"},  32'(cmos_frame_href),  32'd0);
      checkOutput({tag, "_clken"}, 32'(cmos_frame_clken), 32'd0);
      checkOutput({tag, "_data"},  32'(cmos_frame_data),  32'd0);
      checkOutput({tag, "_cnt"},   32'(frame_cnt),        32'd0);
      checkOutput({tag, "_err"},   32'(frame_err),        32'd0);
   endtask

   task automatic checkFrame(input string tag, input logic [7:0] cnt, input logic err);
      checkOutput({tag, "_cnt"}, 32'(frame_cnt), 32'(cnt));
      checkOutput({tag, "_err"}, 32'(frame_err), 32'(err));
   endtask

   // Two-cycle vsync pulse followed by a short blanking gap.
   task automatic sendVsync();
      applyStimulus(1'b1, 1'b0, 8'd0);
      applyStimulus(1'b1, 1'b0, 8'd0);
      repeat (4) applyStimulus(1'b0, 1'b0, 8'd0);
   endtask

   task automatic sendLine(input int nBytes, input logic [7:0] base);
      for (int j = 0; j < nBytes; j++) begin
         applyStimulus(1'b0, 1'b1, base + 8'(j));
      end
      repeat (4) applyStimulus(1'b0, 1'b0, 8'd0);
   endtask

   task automatic goodFrame();
      repeat (3) sendLine(8, 8'h10);
   endtask

   // The enabling vsync edge: the output pulse appears exactly three cycles
   // after the input rise and lasts as long as the input pulse.
   task automatic checkEnableEdge(input string tag);
      applyStimulus(1'b1, 1'b0, 8'd0);
      checkOutput({tag, "_vs_k1"}, 32'(cmos_frame_vsync), 32'd0);
      applyStimulus(1'b1, 1'b0, 8'd0);
      checkOutput({tag, "_vs_k2"}, 32'(cmos_frame_vsync), 32'd0);
      checkOutput({tag, "_quiet"}, 32'(activeCount - activeBase), 32'd0);
      applyStimulus(1'b0, 1'b0, 8'd0);
      checkOutput({tag, "_vs_k3"}, 32'(cmos_frame_vsync), 32'd1);
      applyStimulus(1'b0, 1'b0, 8'd0);
      checkOutput({tag, "_vs_k4"}, 32'(cmos_frame_vsync), 32'd1);
      applyStimulus(1'b0, 1'b0, 8'd0);
      checkOutput({tag, "_vs_k5"}, 32'(cmos_frame_vsync), 32'd0);
      repeat (2) applyStimulus(1'b0, 1'b0, 8'd0);
      checkFrame({tag, "_first"}, 8'd1, 1'b0);
   endtask

   initial begin
      // Reset state.
      repeat (3) applyStimulus(1'b0, 1'b0, 8'd0);
      checkAllZero("reset");
      rst_n = 1'b1;
      repeat (2) applyStimulus(1'b0, 1'b0, 8'd0);

      // First vsync edge and a full frame are swallowed.
      activeBase = activeCount;
      sendVsync();
      goodFrame();
      checkOutput("pre_enable_quiet", 32'(activeCount - activeBase), 32'd0);
      checkOutput("pre_enable_cnt", 32'(frame_cnt), 32'd0);

      // Second edge enables output.
      checkEnableEdge("enable");

      // First enabled line: packing and 3-cycle alignment.
      for (int i = 0; i < 12; i++) begin
         checkOutput($sformatf("line_href_%0d", i),  32'(cmos_frame_href),  32'(expHrefTbl[i]));
         checkOutput($sformatf("line_clken_%0d", i), 32'(cmos_frame_clken), 32'(expClkenTbl[i]));
         checkOutput($sformatf("line_data_%0d", i),  32'(cmos_frame_data),  32'(expDataTbl[i]));
         if (i < 8) begin
            applyStimulus(1'b0, 1'b1, lineBytes[i]);
         end else begin
            applyStimulus(1'b0, 1'b0, 8'd0);
         end
      end
      repeat (2) sendLine(8, 8'h10);
      sendVsync();
      checkFrame("frame1_good", 8'd2, 1'b0);

      goodFrame();
      sendVsync();
      checkFrame("frame2_good", 8'd3, 1'b0);

      // One short line (3 pixels).
      sendLine(8, 8'h10);
      sendLine(6, 8'h20);
      sendLine(8, 8'h10);
      sendVsync();
      checkFrame("short_line", 8'd4, 1'b1);

      goodFrame();
      sendVsync();
      checkFrame("recover", 8'd5, 1'b0);

      // Odd byte count: seven bytes give three strobes, the last byte is lost.
      sendLine(8, 8'h10);
      clkenBase = clkenCount;
      sendLine(7, 8'hA0);
      checkOutput("odd_strobes", 32'(clkenCount - clkenBase), 32'd3);
      checkOutput("odd_last_data", 32'(cmos_frame_data), 32'h0000A4A5);
      sendLine(8, 8'h10);
      sendVsync();
      checkFrame("odd_line", 8'd6, 1'b1);

      goodFrame();
      sendVsync();
      checkFrame("after_odd", 8'd7, 1'b0);

      // Too few lines.
      repeat (2) sendLine(8, 8'h10);
      sendVsync();
      checkFrame("two_lines", 8'd8, 1'b1);

      // 256 good frames: frame_cnt wraps through 255 -> 0.
      goodFrame();
      expCnt = 8'd8;
      for (int f = 0; f < 256; f++) begin
         sendVsync();
         expCnt = expCnt + 8'd1;
         checkFrame($sformatf("wrap_%0d", f), expCnt, 1'b0);
         goodFrame();
      end

      // Asynchronous reset in the middle of an enabled line.
      for (int j = 0; j < 5; j++) begin
         applyStimulus(1'b0, 1'b1, 8'h40 + 8'(j));
      end
      checkOutput("pre_reset_href", 32'(cmos_frame_href), 32'd1);
      rst_n = 1'b0;
      #1;
      checkAllZero("async_reset");
      for (int j = 5; j < 8; j++) begin
         applyStimulus(1'b0, 1'b1, 8'h40 + 8'(j));
      end
      activeBase = activeCount;
      rst_n = 1'b1;
      for (int j = 0; j < 3; j++) begin
         applyStimulus(1'b0, 1'b1, 8'h50 + 8'(j));
      end
      repeat (4) applyStimulus(1'b0, 1'b0, 8'd0);
      checkOutput("partial_line_quiet", 32'(activeCount - activeBase), 32'd0);

      // Qualification restarts: one swallowed frame, then re-enable.
      sendVsync();
      goodFrame();
      checkOutput("requalify_quiet", 32'(activeCount - activeBase), 32'd0);
      checkOutput("requalify_cnt", 32'(frame_cnt), 32'd0);
      checkEnableEdge("reenable");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
